// File: rtl/aes_rx_checker_if.sv
// ---------------------------------------------------------------------------
// aes_rx_checker_if
//   Expected-ciphertext handshake between a block source and aes_rx_checker.
//   exp_valid : source offers a block (qualified by exp_ready)
//   exp_data  : 128-bit expected ciphertext, [127:120] is the first wire byte
//   exp_ready : checker is idle and will take the offered block
//   master modport = block source, slave modport = checker.
// ---------------------------------------------------------------------------
interface aes_rx_checker_if;
    logic         exp_valid;
    logic [127:0] exp_data;
    logic         exp_ready;

    modport master (output exp_valid, output exp_data, input exp_ready);
    modport slave  (input exp_valid, input exp_data, output exp_ready);
endinterface

// File: rtl/aes_rx_checker.sv
// ---------------------------------------------------------------------------
// aes_rx_checker
//   Collects 16 bytes strobed out of an AES chip, compares them with an
//   expected ciphertext block and keeps running totals.
//
//   Parameter TIMEOUT_CYCLES : idle cycles (no received byte) tolerated while
//                              a block is armed before it is abandoned (>= 2).
//   Ports
//     clk, rst_n    : clock, asynchronous active-low reset
//     exp           : aes_rx_checker_if.slave, expected block handshake
//     aes_rx[8:0]   : chip output, [7:0] data, [8] byte strobe (async to clk)
//     total         : blocks concluded (compare or timeout), saturating
//     correct       : blocks that matched, saturating
//     done          : one-cycle pulse when a block concludes
//     match         : result of the concluded block, valid with done
//     timeout       : one-cycle pulse with done when a block is abandoned
//     last_mismatch : last received block that failed compare
//
//   Optional feature macro: AES_CHK_MISMATCH_LOG_EN
//     defined   -> last_mismatch captures rx data on a failed compare
//     undefined -> last_mismatch is tied to zero, no capture register
// ---------------------------------------------------------------------------
module aes_rx_checker #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_rx_checker_if.slave      exp,
    input  logic [8:0]           aes_rx,
    output logic [31:0]          total,
    output logic [31:0]          correct,
    output logic                 done,
    output logic                 match,
    output logic                 timeout,
    output logic [127:0]         last_mismatch
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // The byte event edge is one cycle before the FSM captures it, and the
    // conclusion is registered one cycle after the counter hits zero, so the
    // counter is loaded two short to land done exactly TIMEOUT_CYCLES cycles
    // after the last byte event.
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMPARE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [8:0]      sync1_q, sync2_q;
    logic            sho_prev_q;
    logic            byte_evt;
    logic [127:0]    exp_q, exp_d;
    logic [127:0]    rx_buf;
    logic [3:0]      idx_q, idx_d;
    logic [CW-1:0]   tmo_q, tmo_d;
    logic [31:0]     total_q, total_d;
    logic [31:0]     correct_q, correct_d;
    logic            done_q, done_d;
    logic            match_q, match_d;
    logic            timeout_q, timeout_d;
    logic            capture;
    logic            blk_match;
    logic            ready;

    // Two-flop synchronizer on the whole chip bus; data and strobe travel
    // together so the data sampled on the strobe edge is already settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sho_prev_q <= 1'b0;
        end else begin
            sync1_q    <= aes_rx;
            sync2_q    <= sync1_q;
            sho_prev_q <= sync2_q[8];
        end
    end

    assign byte_evt = sync2_q[8] & ~sho_prev_q;

    // A byte is only taken when the block has not just timed out.
    assign capture   = (state_q == S_COLLECT) && (tmo_q != '0) && byte_evt;
    assign blk_match = (rx_buf == exp_q);

    // One 8-bit lane per wire byte; lane 0 sits at [127:120].
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
        logic [7:0] lane_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                lane_q <= '0;
            else if (capture && (idx_q == 4'(gi)))
                lane_q <= sync2_q[7:0];
        end
        assign rx_buf[127-8*gi -: 8] = lane_q;
    end

    // Ready stays low during the done cycle so a new block is only taken
    // once the previous result has been presented.
    assign ready = (state_q == S_IDLE) && !done_q;

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        total_d   = total_q;
        correct_d = correct_q;
        done_d    = 1'b0;
        match_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Byte events are ignored here, including one coinciding
                // with the accepting handshake.
                if (exp.exp_valid && ready) begin
                    exp_d   = exp.exp_data;
                    idx_d   = 4'd0;
                    tmo_d   = TMO_LOAD;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (tmo_q == '0) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    total_d   = (total_q == '1) ? total_q : total_q + 32'd1;
                    state_d   = S_IDLE;
                end else if (byte_evt) begin
                    idx_d = idx_q + 4'd1;
                    tmo_d = TMO_LOAD;
                    if (idx_q == 4'd15)
                        state_d = S_COMPARE;
                end else begin
                    tmo_d = tmo_q - CW'(1);
                end
            end
            S_COMPARE: begin
                done_d  = 1'b1;
                match_d = blk_match;
                total_d = (total_q == '1) ? total_q : total_q + 32'd1;
                if (blk_match)
                    correct_d = (correct_q == '1) ? correct_q : correct_q + 32'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            exp_q     <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            total_q   <= '0;
            correct_q <= '0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            total_q   <= total_d;
            correct_q <= correct_d;
            done_q    <= done_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef AES_CHK_MISMATCH_LOG_EN
    logic [127:0] last_mm_q;
    // Only failed compares are logged; timeouts leave the log untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_mm_q <= '0;
        else if ((state_q == S_COMPARE) && !blk_match)
            last_mm_q <= rx_buf;
    end
    assign last_mismatch = last_mm_q;
`else
    assign last_mismatch = '0;
`endif

    assign exp.exp_ready = ready;
    assign total         = total_q;
    assign correct       = correct_q;
    assign done          = done_q;
    assign match         = match_q;
    assign timeout       = timeout_q;

endmodule

// File: doc/aes_rx_checker.md
AES_RX_CHECKER -- requirements
Module: aes_rx_checker

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000: clk cycles allowed with no received byte while a block is armed before the block is abandoned.
REQ-002 Port clk  input  1: system clock (50 MHz platform clock); all state updates on the rising edge.
REQ-003 Port rst_n  input  1: asynchronous, active-low reset.
REQ-004 Port exp_valid  input  1: expected-ciphertext offer, qualified by exp_ready.
REQ-005 Port exp_data  input  128: expected ciphertext; bits [127:120] are the first byte on the wire.
REQ-006 Port exp_ready  output  1: high when the checker can accept a new expected block.
REQ-007 Port aes_rx  input  9: chip output; [7:0] byte data, [8] sho strobe; asynchronous to clk.
REQ-008 Port total  output  32: blocks concluded, by compare or by timeout.
REQ-009 Port correct  output  32: blocks whose 16 received bytes equal exp_data.
REQ-010 Port done  output  1: one-cycle pulse when a block concludes.
REQ-011 Port match  output  1: result of the concluded block, valid while done is high.
REQ-012 Port timeout  output  1: one-cycle pulse, coincident with done, when a block is abandoned.
REQ-013 Port last_mismatch  output  128: last received block that failed compare (see Configuration).

Function
REQ-014 aes_rx[8:0] passes through a 2-flop synchronizer on clk; no other logic uses raw aes_rx.
REQ-015 Byte event = synchronized sho 0->1 edge; data is the synchronized aes_rx[7:0] in the same cycle, since the chip holds data stable for at least one chip clock before and while sho is high.
REQ-016 States: IDLE, COLLECT, COMPARE; IDLE is the reset state.
REQ-017 IDLE: exp_ready=1; on exp_valid, latch exp_data, clear the byte index to 0, load the timeout counter, and go to COLLECT.
REQ-018 IDLE: byte events are discarded, including one coinciding with the accepting exp_valid.
REQ-019 COLLECT: exp_ready=0; each byte event writes rx_buf[127-8*idx -: 8], increments idx (4-bit), and reloads the timeout counter.
REQ-020 COLLECT: the event writing idx=15 moves to COMPARE on the next cycle.
REQ-021 COLLECT: the timeout counter decrements each cycle with no byte event; on reaching 0, pulse done=1, timeout=1, match=0, increment total only, and go to IDLE.
REQ-022 COMPARE lasts exactly one cycle: done=1, match=(rx_buf==exp latch), total+1, correct+1 if match, then IDLE.
REQ-023 Latency: done asserts 2 clk cycles after the clk edge that detects the 16th byte event.
REQ-024 Byte events during COMPARE are discarded.
REQ-025 total and correct saturate at 32'hFFFF_FFFF; correct never exceeds total.
REQ-026 exp_ready returns high in the cycle after done.

Reset
REQ-027 rst_n low asynchronously forces: IDLE; total=0, correct=0, done=0, match=0, timeout=0, last_mismatch=0, idx=0; synchronizer flops cleared; exp_ready=1 after release.
REQ-028 Reset during COLLECT abandons the partial block without counting it.

Configuration
REQ-029 Macro AES_CHK_MISMATCH_LOG_EN defined: on a COMPARE with match=0, last_mismatch loads rx_buf; timeouts do not update it.
REQ-030 Macro AES_CHK_MISMATCH_LOG_EN undefined: last_mismatch is held at 128'h0 and no capture register exists.

Verification
REQ-031 Arm exp_data=128'h69c4e0d86a7b0430d8cdb78070b4c55a, then send bytes 69,c4,...,5a -> one done with match=1; total=1, correct=1.
REQ-032 Same expected block, but the 10th byte is 0xcc instead of 0xcd -> match=0, total=1, correct=0; with the macro defined, last_mismatch shows cc at bits [55:48].
REQ-033 TIMEOUT_CYCLES=50, arm, send 5 bytes, then stop -> done and timeout pulse 50 cycles after the 5th byte event; total=1, correct=0; state returns to IDLE.
REQ-034 Send 3 byte events in IDLE, then arm and send 16 correct bytes -> match=1; the stray bytes have no effect.
REQ-035 Assert rst_n=0 after 8 bytes, release, arm, and send 16 bytes -> total=1, correct=1; no count from the aborted block.
REQ-036 Preload total and correct to 32'hFFFF_FFFF by force, then run one matching block -> both remain 32'hFFFF_FFFF.
